vga_tmds_encoder: RTL and testbench
===================================

Name: vga_tmds_encoder

Overview:
- Downstream of the pixel/raster generator. Consumes its 4-bit-per-component colour, sync and data-enable outputs.
- Produces three DVI 1.0 TMDS 10-bit parallel words per pixel clock for the GPDI serializer/DDR output stage.
- Pipelined, with a per-channel running-disparity (DC balance) counter. Sync and DE leave with the same latency as the data.

Parameters:
- COLOR_BITS, 4, width of each input colour component. Must be ≤ 8.
- LATENCY, 3, fixed pipeline depth in clk cycles, input to output. Informational only; not to be overridden.

Ports:
- clk  input  1  pixel clock. Single clock domain.
- reset  input  1  synchronous, active-high.
- vga_r  input  COLOR_BITS  red component.
- vga_g  input  COLOR_BITS  green component.
- vga_b  input  COLOR_BITS  blue component.
- vga_hs  input  1  horizontal sync, raw level as generated.
- vga_vs  input  1  vertical sync, raw level as generated.
- vga_de  input  1  active-video enable.
- tmds_r  output  10  red channel word; bit 0 is transmitted first.
- tmds_g  output  10  green channel word.
- tmds_b  output  10  blue channel word.
- out_hs  output  1  vga_hs delayed by LATENCY.
- out_vs  output  1  vga_vs delayed by LATENCY.
- out_de  output  1  vga_de delayed by LATENCY.

Behaviour:
- Stage 1: register all inputs and expand colour to 8 bits (see Optional Feature).
- Stage 2, per channel:
  - n1d = number of ones in d[7:0].
  - Use XNOR if n1d > 4, or if n1d == 4 and d[0] == 0; otherwise XOR.
  - q_m[0] = d[0]; q_m[i] = q_m[i-1] XOR/XNOR d[i] for i = 1..7.
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m, the ones count of q_m[7:0], de and the control bits.
- Stage 3, DC balance. cnt is 5-bit signed, range −8..+8, one per channel. n1/n0 are the ones/zeros counts of q_m[7:0].
  - Case A, cnt == 0 or n1 == n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1 − n0) : (n0 − n1).
  - Case B, (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (n0 − n1).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·~q_m[8] + (n1 − n0).
- Blanking (de low at stage 3):
  - Output the control code for {c1,c0}: 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011.
  - Force cnt to 0.
  - Blue channel uses c0 = hs, c1 = vs. Red and green use c = 00.
- Latency: exactly 3 cycles for data, sync and de alike. No bubbles; every input cycle produces one output cycle.
- Reset:
  - All pipeline registers clear; cnt = 0.
  - tmds_r/g/b = 1101010100; out_hs = out_vs = out_de = 0.
  - Reset asserted mid-line discards in-flight pixels. The first valid output appears 3 cycles after reset deasserts.
- de edges:
  - A blank→active transition starts from cnt = 0.
  - An active→blank transition emits the control code in the same cycle de is low at stage 3. No extra word is produced.
- No handshake or backpressure. Input must be presented every clk.

Optional Feature:
- Macro: TMDS_COLOR_EXPAND_EN.
- Defined: component c is expanded by bit replication, e.g. 4-bit {c,c}, so 4'hF → 8'hFF and 4'h8 → 8'h88.
- Undefined: zero-padded MSB-aligned, {c, {(8−COLOR_BITS){0}}}, so 4'hF → 8'hF0.
- Encoding is otherwise identical.

Decomposition:
- Package tmds_pkg holds:
  - the four 10-bit control-code constants;
  - the TMDS_LATENCY constant (3);
  - the cnt width constant (5);
  - a function for the 8-bit popcount.
- One sub-module, tmds_channel: stages 2–3 plus the cnt register for one channel, with inputs d[7:0], de and c[1:0]. Instantiated three times.
- The top handles stage 1, colour expansion and the sync/de delay line.

Test Plan:
- Reset, then hold vga_de = 0 with hs = 0, vs = 0 → after 3 clk: tmds_b = 1101010100; tmds_r = tmds_g = 1101010100.
- vga_de = 0, hs = 1, vs = 0 → tmds_b = 0010101011. hs = 0, vs = 1 → 0101010100. hs = vs = 1 → 1010101011. out_hs/out_vs track the inputs with a 3-cycle delay.
- Macro defined, de = 1, vga_b = 0 for consecutive pixels from cnt = 0 → tmds_b words alternate 0100000000, 1111111111, 0100000000, …; blue cnt sequence −8, +2, −6, …
- Macro defined, de = 1, vga_r = 4'hF first pixel after blanking → tmds_r = 1000000000; red cnt = −8.
- Toggle de mid-stream: de 1→0→1 → a control word appears exactly 3 cycles after de falls, and the first data word after re-entry is encoded with cnt = 0.
- Assert reset while de = 1 with data flowing → the next cycle shows 1101010100 on all channels and out_de = 0. After release, outputs match a golden model fed the same post-reset stimulus.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants, types and helpers for the DVI 1.0 TMDS encoder.
// Optional build macro consumed by the top: TMDS_COLOR_EXPAND_EN.
package tmds_pkg;

  localparam int TMDS_LATENCY = 3;
  localparam int CNT_W = 5;

  // Control words indexed by {c1,c0}; bit 0 is serialised first.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] w;
    case (c)
      2'b00:   w = CTRL_00;
      2'b01:   w = CTRL_01;
      2'b10:   w = CTRL_10;
      default: w = CTRL_11;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/vga_tmds_encoder_if.sv
// Raster-side inputs and TMDS-side outputs of the encoder as one bundle.
// There is no valid/ready: every clk edge is a transfer on both sides, input is presented every cycle.
interface vga_tmds_encoder_if #(parameter int COLOR_BITS = 4);
  logic [COLOR_BITS-1:0] vga_r;
  logic [COLOR_BITS-1:0] vga_g;
  logic [COLOR_BITS-1:0] vga_b;
  logic                  vga_hs;
  logic                  vga_vs;
  logic                  vga_de;
  logic [9:0]            tmds_r;
  logic [9:0]            tmds_g;
  logic [9:0]            tmds_b;
  logic                  out_hs;
  logic                  out_vs;
  logic                  out_de;

  modport master (
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    input  tmds_r, tmds_g, tmds_b, out_hs, out_vs, out_de
  );

  modport slave (
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    output tmds_r, tmds_g, tmds_b, out_hs, out_vs, out_de
  );
endinterface

// File: rtl/tmds_channel.sv
// One TMDS lane: transition-minimising stage (q_m) followed by the DC-balance
// stage with its running disparity counter. Two register stages.
module tmds_channel
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       de,
  input  logic [1:0] c,
  output logic [9:0] tmds
);

  localparam logic signed [CNT_W-1:0] ZERO  = '0;
  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  logic [3:0]              n1d;
  logic                    use_xnor;
  logic [8:0]              q_m_d, q_m_q;
  logic [3:0]              n1_d, n1_q;
  logic                    de_q;
  logic [1:0]              c_q;
  logic signed [CNT_W-1:0] diff;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [9:0]              tmds_d, tmds_q;

  always_comb begin
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q_m_d    = '0;
    q_m_d[0] = d[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d[i]) : (q_m_d[i-1] ^ d[i]);
    q_m_d[8] = ~use_xnor;
    n1_d     = popcount8(q_m_d[7:0]);
  end

  // diff = n1 - n0 = 2*n1 - 8, kept in the counter's signed width.
  always_comb begin
    diff   = $signed(CNT_W'({n1_q, 1'b0})) - EIGHT;
    tmds_d = CTRL_00;
    cnt_d  = cnt_q;
    if (!de_q) begin
      tmds_d = ctrl_code(c_q);
      cnt_d  = ZERO;
    end else if ((cnt_q == ZERO) || (diff == ZERO)) begin
      tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d  = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > ZERO) && (diff > ZERO)) || ((cnt_q < ZERO) && (diff < ZERO))) begin
      tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d  = cnt_q + (q_m_q[8] ? TWO : ZERO) - diff;
    end else begin
      tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d  = cnt_q - (q_m_q[8] ? ZERO : TWO) + diff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_m_q  <= '0;
      n1_q   <= '0;
      de_q   <= 1'b0;
      c_q    <= 2'b00;
      cnt_q  <= ZERO;
      tmds_q <= CTRL_00;
    end else begin
      q_m_q  <= q_m_d;
      n1_q   <= n1_d;
      de_q   <= de;
      c_q    <= c;
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: rtl/vga_tmds_encoder.sv
// VGA-to-DVI TMDS encoder top: input register, colour widening, sync/de delay line.
// Define TMDS_COLOR_EXPAND_EN for bit-replicated colour widening; default is zero padding.
module vga_tmds_encoder
  import tmds_pkg::*;
#(
  parameter int COLOR_BITS = 4,
  parameter int LATENCY    = TMDS_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_tmds_encoder_if.slave      bus
);

  logic [7:0] r_d, g_d, b_d;
  logic [7:0] r_q, g_q, b_q;
  sync_t      sync_d [LATENCY];
  sync_t      sync_q [LATENCY];
  logic [9:0] tmds_r, tmds_g, tmds_b;

  function automatic logic [7:0] widen(input logic [COLOR_BITS-1:0] c);
    logic [7:0] w;
`ifdef TMDS_COLOR_EXPAND_EN
    for (int i = 0; i < 8; i++) w[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
`else
    w = 8'(c) << (8 - COLOR_BITS);
`endif
    return w;
  endfunction

  // sync_q[0] is the stage-1 copy feeding the lanes; the tail is the output.
  always_comb begin
    r_d       = widen(bus.vga_r);
    g_d       = widen(bus.vga_g);
    b_d       = widen(bus.vga_b);
    sync_d[0] = {bus.vga_vs, bus.vga_hs, bus.vga_de};
    for (int i = 1; i < LATENCY; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      for (int i = 0; i < LATENCY; i++) sync_q[i] <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      for (int i = 0; i < LATENCY; i++) sync_q[i] <= sync_d[i];
    end
  end

  tmds_channel u_red (
    .clk(clk), .reset(reset), .d(r_q), .de(sync_q[0].de), .c(2'b00), .tmds(tmds_r)
  );

  tmds_channel u_green (
    .clk(clk), .reset(reset), .d(g_q), .de(sync_q[0].de), .c(2'b00), .tmds(tmds_g)
  );

  // Only the blue lane carries sync: c1 = vs, c0 = hs.
  tmds_channel u_blue (
    .clk(clk), .reset(reset), .d(b_q), .de(sync_q[0].de),
    .c({sync_q[0].vs, sync_q[0].hs}), .tmds(tmds_b)
  );

  assign bus.tmds_r = tmds_r;
  assign bus.tmds_g = tmds_g;
  assign bus.tmds_b = tmds_b;
  assign bus.out_hs = sync_q[LATENCY-1].hs;
  assign bus.out_vs = sync_q[LATENCY-1].vs;
  assign bus.out_de = sync_q[LATENCY-1].de;

endmodule

// File: tb/tb_vga_tmds_encoder.sv
// Scoreboard bench for vga_tmds_encoder: random raster stimulus, behavioural TMDS model,
// expected words queued at issue time and popped by an independent monitor.
module tb_vga_tmds_encoder;

  localparam int CB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_tmds_encoder_if #(.COLOR_BITS(CB)) bus ();

  vga_tmds_encoder #(.COLOR_BITS(CB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit         rst;
    logic [3:0] r, g, b;
    bit         hs, vs, de;
  } pix_t;

  pix_t        hist[$];
  int          cnt_m[3];
  logic [32:0] exp_q[$];
  string       phase_q[$];
  string       phase = "reset";
  int          checks = 0;
  int          failures = 0;
  logic [9:0]  ctrl_tbl[4];

  function automatic logic [7:0] widen(input logic [3:0] c);
`ifdef TMDS_COLOR_EXPAND_EN
    return {c, c};
`else
    return {c, 4'h0};
`endif
  endfunction

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic encode(input logic [7:0] d, inout int cnt, output logic [9:0] w);
    bit         use_xnor;
    logic [8:0] qm;
    int         n1, n0;
    use_xnor = (ones8(d) > 4) || (ones8(d) == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    n1 = ones8(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt = cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - (qm[8] ? 0 : 2) + (n1 - n0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] b, input bit hs, input bit vs, input bit de);
    pix_t       p;
    logic [9:0] wr, wg, wb;
    bit         any_rst;
    @(negedge clk);
    reset = rst;
    bus.vga_r = r;
    bus.vga_g = g;
    bus.vga_b = b;
    bus.vga_hs = hs;
    bus.vga_vs = vs;
    bus.vga_de = de;
    p.rst = rst; p.r = r; p.g = g; p.b = b; p.hs = hs; p.vs = vs; p.de = de;
    hist.push_back(p);
    if (hist.size() > 3) void'(hist.pop_front());
    // The word leaving at the coming edge is the pixel issued two edges ago,
    // unless reset was seen at any edge along its path.
    any_rst = (hist.size() < 3);
    foreach (hist[i]) if (hist[i].rst) any_rst = 1'b1;
    if (any_rst) begin
      cnt_m = '{0, 0, 0};
      exp_q.push_back({ctrl_tbl[0], ctrl_tbl[0], ctrl_tbl[0], 3'b000});
    end else begin
      p = hist[0];
      if (!p.de) begin
        cnt_m = '{0, 0, 0};
        wr = ctrl_tbl[0];
        wg = ctrl_tbl[0];
        wb = ctrl_tbl[{p.vs, p.hs}];
      end else begin
        encode(widen(p.r), cnt_m[0], wr);
        encode(widen(p.g), cnt_m[1], wg);
        encode(widen(p.b), cnt_m[2], wb);
      end
      exp_q.push_back({wr, wg, wb, p.hs, p.vs, p.de});
    end
    phase_q.push_back(phase);
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    logic [32:0] exp_w, act_w;
    string       nm;
    #1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      nm    = phase_q.pop_front();
      act_w = {bus.tmds_r, bus.tmds_g, bus.tmds_b, bus.out_hs, bus.out_vs, bus.out_de};
      checks++;
      if (act_w !== exp_w) begin
        failures++;
        $display("FAIL %s t=%0t got r=%b g=%b b=%b hs/vs/de=%b want r=%b g=%b b=%b hs/vs/de=%b",
                 nm, $time, act_w[32:23], act_w[22:13], act_w[12:3], act_w[2:0],
                 exp_w[32:23], exp_w[22:13], exp_w[12:3], exp_w[2:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit de_pat[10];
    ctrl_tbl[0] = 10'b1101010100;
    ctrl_tbl[1] = 10'b0010101011;
    ctrl_tbl[2] = 10'b0101010100;
    ctrl_tbl[3] = 10'b1010101011;
    de_pat = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1};
    bus.vga_r = '0; bus.vga_g = '0; bus.vga_b = '0;
    bus.vga_hs = 1'b0; bus.vga_vs = 1'b0; bus.vga_de = 1'b0;

    phase = "reset";
    repeat (4) drive(1, 4'h0, 4'h0, 4'h0, 0, 0, 0);

    phase = "blank_sync";
    for (int s = 0; s < 4; s++) repeat (5) drive(0, rnd4(), rnd4(), rnd4(), s[0], s[1], 0);

    phase = "blue_zero_red_f";
    repeat (10) drive(0, 4'hF, rnd4(), 4'h0, 0, 0, 1);

    phase = "de_toggle";
    for (int i = 0; i < 10; i++)
      drive(0, rnd4(), rnd4(), rnd4(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), de_pat[i]);

    phase = "random";
    repeat (300)
      drive(0, rnd4(), rnd4(), rnd4(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) != 0);

    phase = "reset_mid";
    repeat (5) drive(0, rnd4(), rnd4(), rnd4(), 0, 0, 1);
    repeat (2) drive(1, rnd4(), rnd4(), rnd4(), 0, 0, 1);
    phase = "post_reset";
    repeat (40)
      drive(0, rnd4(), rnd4(), rnd4(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) != 0);

    phase = "flush";
    repeat (4) drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
